// File: rtl/prbs31_pkg.sv
// Shared types and constants for the PRBS31 (x^31 + x^28 + 1) checker family.
package prbs31_pkg;

  localparam int unsigned PRBS_W = 31;
  localparam int unsigned TAP_A  = 31;
  localparam int unsigned TAP_B  = 28;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ERRB_W = 4;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/prbs31_if.sv
// Byte stream in, lock/error status out, for the PRBS31 checker.
interface prbs31_if #(
  parameter int unsigned CNT_W = 16
);
  import prbs31_pkg::*;

  logic              clr;
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              locked;
  logic              err_pulse;
  logic [ERRB_W-1:0] err_bits;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output clr, in_valid, in_data,
    input  locked, err_pulse, err_bits, err_count
  );

  modport slave (
    input  clr, in_valid, in_data,
    output locked, err_pulse, err_bits, err_count
  );
endinterface

// File: rtl/prbs31_predict8.sv
// Predicts the next 8 PRBS31 bits from the last 31; pred[7] is the earliest bit.
module prbs31_predict8
  import prbs31_pkg::*;
(
  input  logic [PRBS_W-1:0] hist,
  output logic [BYTE_W-1:0] pred
);

  // hist[0] is the newest bit, so s[n+j-31] = hist[30-j] and s[n+j-28] = hist[27-j].
  always_comb begin
    pred = '0;
    for (int j = 0; j < int'(BYTE_W); j++) begin
      pred[BYTE_W-1-j] = hist[TAP_A-1-j] ^ hist[TAP_B-1-j];
    end
  end

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 receive checker: self-synchronises, locks, then free-runs and counts bit errors.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int unsigned LOCK_BYTES = 8,
  parameter int unsigned LOSS_BYTES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  prbs31_if.slave  bus
);

  localparam int unsigned SEED_BYTES = 4;
  localparam int unsigned SEED_W     = 2;
  localparam int unsigned GOOD_W     = $clog2(LOCK_BYTES + 1);
  localparam int unsigned BAD_W      = $clog2(LOSS_BYTES + 1);
  localparam int unsigned SHIFT_W    = PRBS_W - BYTE_W;

  state_t              state_q, state_d;
  logic [PRBS_W-1:0]   hist_q, hist_d;
  logic [SEED_W-1:0]   seed_q, seed_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [BAD_W-1:0]    bad_q, bad_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic [ERRB_W-1:0]   err_bits_q, err_bits_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W:0]      sum;
  logic [BYTE_W-1:0]   pred;
  logic [BYTE_W-1:0]   diff;
  logic [ERRB_W-1:0]   err_c;

  prbs31_predict8 u_predict (
    .hist (hist_q),
    .pred (pred)
  );

  assign diff = bus.in_data ^ pred;

  // Number of bit errors in the current byte against the prediction.
  always_comb begin
    err_c = '0;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      err_c = err_c + ERRB_W'(diff[i]);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= SEED;
    else       state_q <= state_d;
  end

  // Next state, history, counters and status outputs.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    seed_d      = seed_q;
    good_d      = good_q;
    bad_d       = bad_q;
    err_bits_d  = '0;
    err_pulse_d = 1'b0;
    count_d     = bus.clr ? '0 : count_q;
    sum         = '0;

    if (bus.in_valid) begin
      unique case (state_q)
        SEED: begin
          hist_d = {hist_q[SHIFT_W-1:0], bus.in_data};
          if (seed_q == SEED_W'(SEED_BYTES - 1)) begin
            state_d = VERIFY;
            seed_d  = '0;
            good_d  = '0;
          end else begin
            seed_d = seed_q + SEED_W'(1);
          end
        end

        VERIFY: begin
          // An all-zero history predicts all zeros forever; never let it lock.
          if (hist_q == '0) begin
            state_d = SEED;
            hist_d  = '0;
            seed_d  = '0;
            good_d  = '0;
          end else begin
            hist_d = {hist_q[SHIFT_W-1:0], bus.in_data};
            if (err_c != '0) begin
              good_d = '0;
            end else if (good_q == GOOD_W'(LOCK_BYTES - 1)) begin
              state_d = LOCKED;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end
        end

        LOCKED: begin
          hist_d      = {hist_q[SHIFT_W-1:0], pred};
          err_bits_d  = err_c;
          err_pulse_d = (err_c != '0);
          sum         = {1'b0, count_d} + (CNT_W + 1)'(err_c);
          count_d     = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
          if (err_c != '0) begin
            if (bad_q == BAD_W'(LOSS_BYTES - 1)) begin
              state_d = SEED;
              hist_d  = '0;
              seed_d  = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + BAD_W'(1);
            end
          end else begin
            bad_d = '0;
          end
        end

        default: state_d = SEED;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hist_q      <= '0;
      seed_q      <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_bits_q  <= '0;
      count_q     <= '0;
    end else begin
      hist_q      <= hist_d;
      seed_q      <= seed_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_bits_q  <= err_bits_d;
      count_q     <= count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_bits  = err_bits_q;
  assign bus.err_count = count_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: a 16-bit and a 4-bit counter instance share one stream.
module tb_prbs31_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  int checks = 0;
  int errors = 0;
  logic [30:0] gen_st;

  prbs31_if #(.CNT_W(16)) bus_a ();
  prbs31_if #(.CNT_W(4))  bus_b ();

  assign bus_a.clr      = clr;
  assign bus_a.in_valid = in_valid;
  assign bus_a.in_data  = in_data;
  assign bus_b.clr      = clr;
  assign bus_b.in_valid = in_valid;
  assign bus_b.in_data  = in_data;

  prbs31_checker #(.LOCK_BYTES(8), .LOSS_BYTES(4), .CNT_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  prbs31_checker #(.LOCK_BYTES(8), .LOSS_BYTES(4), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    logic [7:0] mask;
    bit         c;
    bit         lk;
    bit         p;
    logic [3:0] bits;
    int         cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bit-serial reference generator, bit 7 of each byte is the earliest bit.
  task automatic next_byte(output logic [7:0] b);
    logic nb;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      nb     = gen_st[30] ^ gen_st[27];
      gen_st = {gen_st[29:0], nb};
      b      = {b[6:0], nb};
    end
  endtask

  task automatic step_raw(input bit v, input logic [7:0] d, input bit c);
    in_valid = v;
    in_data  = d;
    clr      = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic step(input bit v, input logic [7:0] mask, input bit c);
    logic [7:0] b;
    b = 8'h00;
    if (v) begin
      next_byte(b);
      b = b ^ mask;
    end
    step_raw(v, b, c);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, 32'(bus_a.locked), 32'd0);
    check({tag, "_pulse"},  32'(bus_a.err_pulse), 32'd0);
    check({tag, "_bits"},   32'(bus_a.err_bits), 32'd0);
    check({tag, "_cnt_a"},  32'(bus_a.err_count), 32'd0);
    check({tag, "_cnt_b"},  32'(bus_b.err_count), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Twelve valid bytes to lock; optional bubbles must not change the byte count.
  task automatic lock_stream(input string tag, input bit bubbles);
    for (int i = 1; i <= 12; i++) begin
      if (bubbles && (i % 3 == 0)) begin
        step(1'b0, 8'h00, 1'b0);
        check($sformatf("%s_bubble%0d_locked", tag, i), 32'(bus_a.locked), 32'd0);
      end
      step(1'b1, 8'h00, 1'b0);
      check($sformatf("%s_byte%0d_locked", tag, i), 32'(bus_a.locked), 32'(i == 12));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int lk_seen;

    tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 0};
    tbl[2]  = '{1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 4'd1, 1};
    tbl[3]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 0};
    tbl[6]  = '{1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 4'd2, 2};
    tbl[7]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 0};
    tbl[8]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 4'd8, 8};
    tbl[9]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 4'd8, 16};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 16};
    tbl[11] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 4'd8, 24};
    tbl[12] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd8, 32};
    tbl[13] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 32};

    gen_st = 31'h7FFF_FFFF;
    do_reset();

    // Clean lock and 1000-byte clean run.
    lock_stream("lock", 1'b0);
    pulses = 0;
    for (int i = 0; i < 988; i++) begin
      step(1'b1, 8'h00, 1'b0);
      if (bus_a.err_pulse || bus_a.err_bits != 4'd0) pulses++;
    end
    check("clean_pulses", 32'(pulses), 32'd0);
    check("clean_cnt", 32'(bus_a.err_count), 32'd0);
    check("clean_locked", 32'(bus_a.locked), 32'd1);

    // Single-bit error, clr, then loss of lock.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].mask, tbl[i].c);
      check($sformatf("tbl%0d_locked", i), 32'(bus_a.locked), 32'(tbl[i].lk));
      check($sformatf("tbl%0d_pulse", i),  32'(bus_a.err_pulse), 32'(tbl[i].p));
      check($sformatf("tbl%0d_bits", i),   32'(bus_a.err_bits), 32'(tbl[i].bits));
      check($sformatf("tbl%0d_cnt", i),    32'(bus_a.err_count), 32'(tbl[i].cnt));
    end

    // Relock: tbl[13] was the first of twelve valid bytes.
    for (int i = 2; i <= 12; i++) begin
      step(1'b1, 8'h00, 1'b0);
      check($sformatf("relock_byte%0d_locked", i), 32'(bus_a.locked), 32'(i == 12));
    end
    check("relock_cnt_held", 32'(bus_a.err_count), 32'd32);

    // Saturation on the 4-bit instance, then clr with a 2-bit error.
    step(1'b1, 8'h00, 1'b1);
    check("sat_clr_a", 32'(bus_a.err_count), 32'd0);
    check("sat_clr_b", 32'(bus_b.err_count), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 8'hFF, 1'b0);
      check($sformatf("sat%0d_a", i), 32'(bus_a.err_count), 32'(8 * i));
      check($sformatf("sat%0d_b", i), 32'(bus_b.err_count), 32'(i == 1 ? 8 : 15));
    end
    step(1'b1, 8'h00, 1'b0);
    check("sat_hold_b", 32'(bus_b.err_count), 32'd15);
    check("sat_locked", 32'(bus_a.locked), 32'd1);
    step(1'b1, 8'h11, 1'b1);
    check("clr_err_bits", 32'(bus_a.err_bits), 32'd2);
    check("clr_err_a", 32'(bus_a.err_count), 32'd2);
    check("clr_err_b", 32'(bus_b.err_count), 32'd2);

    // Async reset mid-LOCKED with live status.
    step(1'b1, 8'h01, 1'b0);
    check("pre_rst_pulse", 32'(bus_a.err_pulse), 32'd1);
    check("pre_rst_cnt", 32'(bus_a.err_count), 32'd3);
    #2;
    rst_n = 1'b1;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b0;

    // Relock with bubbles, lock timing counted in valid bytes.
    lock_stream("bubble", 1'b1);

    // All-zero line never locks.
    do_reset();
    lk_seen = 0;
    pulses  = 0;
    for (int i = 0; i < 100; i++) begin
      step_raw(1'b1, 8'h00, 1'b0);
      if (bus_a.locked) lk_seen++;
      if (bus_a.err_pulse) pulses++;
    end
    check("zero_locked_seen", 32'(lk_seen), 32'd0);
    check("zero_pulses", 32'(pulses), 32'd0);
    check("zero_cnt", 32'(bus_a.err_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Receive-side companion to the 8-bit-per-cycle PRBS31 generator (polynomial x^31 + x^28 + 1).
- Accepts one byte per valid cycle, self-synchronises to the incoming sequence, declares lock and counts bit errors.
- Once locked it free-runs its predictor, so a line error does not propagate into later predictions.
- Sits on the receive path of the loopback/BERT test harness; outputs drive status pins.

Parameters:
- LOCK_BYTES, 8: consecutive error-free bytes in VERIFY needed to declare lock.
- LOSS_BYTES, 4: consecutive errored bytes in LOCKED that drop lock.
- CNT_W, 16: width of the saturating bit-error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-high.
- clr  in  1  synchronous clear of err_count only. Does not affect state or lock.
- in_valid  in  1  in_data holds a new byte this cycle.
- in_data  in  8  received byte. Bit 7 is the earliest bit in time, bit 0 the latest.
- locked  out  1  high while state == LOCKED.
- err_pulse  out  1  one-cycle pulse: the byte just checked in LOCKED had at least one bit error.
- err_bits  out  4  number of errored bits (0..8) in the byte just checked. Valid with err_pulse; 0 otherwise.
- err_count  out  CNT_W  saturating total of errored bits while LOCKED.

Behaviour:
- Serial rule: s[n] = s[n-31] ^ s[n-28].
- hist: 31-bit register holding the last 31 sequence bits.
- Prediction of the next 8 bits p[0..7] (p[0] earliest) uses only hist, since every tap is at least 28 bits back.
- On every in_valid cycle, hist shifts left by 8 and appends the newest bits.
- Reset (async, rst_n=1):
  - state=SEED, hist=0, byte/good/bad counters=0.
  - locked=0, err_pulse=0, err_bits=0, err_count=0.
  - Reset mid-operation discards lock immediately.
- Cycles with in_valid=0: no state change; err_pulse=0, err_bits=0.
- SEED:
  - hist takes in_data. After 4 valid bytes (32 bits ≥ 31), go to VERIFY with good=0.
- VERIFY:
  - Compare in_data with the prediction. hist takes in_data (received bits), giving self-synchronisation.
  - Mismatch: good=0.
  - Match: good+1. When good reaches LOCK_BYTES, go to LOCKED with bad=0.
  - All-zero guard: if hist==0 on a valid cycle, return to SEED and do not count the byte as good. An all-zero line must never lock.
  - No error counting in VERIFY.
- LOCKED:
  - hist takes the predicted bits (free-run).
  - err_bits = popcount(in_data ^ pred), registered; err_pulse = (err_bits != 0).
  - err_count += err_bits, saturating at 2^CNT_W-1.
  - Errored byte: bad+1. Clean byte: bad=0.
  - When bad reaches LOSS_BYTES, go to SEED with hist=0 and locked=0 on the next cycle. That byte's errors are still counted.
- Latency: all outputs are registered. Results for byte k appear one cycle after its in_valid cycle. locked rises the cycle after the LOCK_BYTES-th good byte.
- clr together with an error in the same cycle: err_count = err_bits of that byte (clear, then add).
- err_count holds its value across loss of lock.

Decomposition:
- Package prbs31_pkg:
  - state enum {SEED, VERIFY, LOCKED}
  - tap constants TAP_A=31, TAP_B=28
  - PRBS_W=31
- Sub-module prbs31_predict8: purely combinational, hist[30:0] -> pred[7:0]. Shared with future generator variants.
- popcount stays inline.

Test Plan:
- Clean lock: generator seeded 0x7FFFFFFF, streamed continuously → locked rises exactly after 4+8=12 valid bytes plus 1 cycle; err_count=0 after 1000 bytes.
- Single-bit error: flip bit 3 of byte 50 after lock → err_pulse for one cycle, err_bits=1, err_count=1, locked stays 1, next bytes clean (no propagation).
- All-zero input: 100 bytes of 0x00 → locked never asserts; state cycles SEED/VERIFY.
- Loss of lock: after lock, invert 4 consecutive bytes → err_bits=8 each, err_count=32, locked falls after the 4th; resume clean stream → relocks after 12 further valid bytes.
- Saturation and clr: CNT_W=4, inject 3 bytes with 8 errors each → err_count=15; then clr asserted in the same cycle as a 2-bit error → err_count=2.
- Reset/bubbles: gaps with in_valid=0 inside the stream → identical lock timing counted in valid bytes; assert rst_n mid-LOCKED → all outputs 0 in the same cycle (async), relock after 12 bytes.
